// File: rtl/cpu_control_sequencer.sv
// Micro-step controller for the 8-bit accumulator CPU: walks fetch/execute T-states from
// opcode and flags, drives one-cycle control strobes, stretches RAM steps on mem_rdy with timeout.
module cpu_control_sequencer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  input  logic       mem_rdy,
  output logic       pc_out,
  output logic       ir_out,
  output logic       a_out,
  output logic       alu_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ir_load,
  output logic       a_load,
  output logic       b_load,
  output logic       out_load,
  output logic       flags_load,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic       alu_sub,
  output logic       instr_done,
  output logic       halted,
  output logic       bus_err,
  output logic [2:0] tstate
);

  typedef enum logic [2:0] {
    F0   = 3'd0,
    F1   = 3'd1,
    E0   = 3'd2,
    E1   = 3'd3,
    E2   = 3'd4,
    HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic pc_out, ir_out, a_out, alu_out;
    logic pc_inc, pc_load, mar_load, ir_load;
    logic a_load, b_load, out_load, flags_load;
    logic ram_rd, ram_wr, alu_sub, instr_done;
  } strobe_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state, next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic              wait_step, timeout;
  strobe_t           s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= F0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (ena) begin
      state    <= next;
      err_q    <= err_q | timeout;
      wait_cnt <= (wait_step && !mem_rdy && !timeout) ? wait_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    s         = '0;
    next      = state;
    wait_step = 1'b0;
    case (state)
      F0: begin
        s.pc_out   = 1'b1;
        s.mar_load = 1'b1;
        next       = F1;
      end
      F1: begin
        wait_step = 1'b1;
        s.ram_rd  = 1'b1;
        if (mem_rdy) begin
          s.ir_load = 1'b1;
          s.pc_inc  = 1'b1;
          next      = E0;
        end
      end
      E0: begin
        next         = F0;
        s.instr_done = 1'b1;
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            s.ir_out     = 1'b1;
            s.mar_load   = 1'b1;
            s.instr_done = 1'b0;
            next         = E1;
          end
          4'h5: begin
            s.ir_out = 1'b1;
            s.a_load = 1'b1;
          end
          4'h6: begin
            s.ir_out  = 1'b1;
            s.pc_load = 1'b1;
          end
          4'h7: begin
            s.ir_out  = flag_c;
            s.pc_load = flag_c;
          end
          4'h8: begin
            s.ir_out  = flag_z;
            s.pc_load = flag_z;
          end
          4'hE: begin
            s.a_out    = 1'b1;
            s.out_load = 1'b1;
          end
          4'hF: next = HALT;
          default: ;
        endcase
      end
      E1: begin
        wait_step = 1'b1;
        case (opcode)
          4'h1: begin
            s.ram_rd = 1'b1;
            if (mem_rdy) begin
              s.a_load     = 1'b1;
              s.instr_done = 1'b1;
              next         = F0;
            end
          end
          4'h2, 4'h3: begin
            s.ram_rd = 1'b1;
            if (mem_rdy) begin
              s.b_load = 1'b1;
              next     = E2;
            end
          end
          4'h4: begin
            s.a_out  = 1'b1;
            s.ram_wr = 1'b1;
            if (mem_rdy) begin
              s.instr_done = 1'b1;
              next         = F0;
            end
          end
          default: begin
            wait_step = 1'b0;
            next      = F0;
          end
        endcase
      end
      E2: begin
        s.alu_out    = 1'b1;
        s.a_load     = 1'b1;
        s.flags_load = 1'b1;
        s.alu_sub    = (opcode == 4'h3);
        s.instr_done = 1'b1;
        next         = F0;
      end
      HALT: next = HALT;
      default: next = F0;
    endcase
    // The cycle that would reach MAX_WAIT stalled cycles aborts to HALT instead.
    timeout = wait_step && !mem_rdy && (wait_cnt == WAIT_LAST);
    if (timeout) next = HALT;
  end

  strobe_t so;
  assign so = (rst || !ena) ? strobe_t'('0) : s;

  assign pc_out     = so.pc_out;
  assign ir_out     = so.ir_out;
  assign a_out      = so.a_out;
  assign alu_out    = so.alu_out;
  assign pc_inc     = so.pc_inc;
  assign pc_load    = so.pc_load;
  assign mar_load   = so.mar_load;
  assign ir_load    = so.ir_load;
  assign a_load     = so.a_load;
  assign b_load     = so.b_load;
  assign out_load   = so.out_load;
  assign flags_load = so.flags_load;
  assign ram_rd     = so.ram_rd;
  assign ram_wr     = so.ram_wr;
  assign alu_sub    = so.alu_sub;
  assign instr_done = so.instr_done;

  // Status outputs keep showing state when frozen, but read as zero under reset.
  assign halted  = !rst && (state == HALT);
  assign bus_err = !rst && err_q;
  assign tstate  = rst ? 3'd0 : state;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: steps each instruction class cycle by cycle
// and compares tstate/strobes/status against hand-derived expectations.
module tb_cpu_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, ena, flag_c, flag_z, mem_rdy;
  logic [3:0] opcode;
  logic pc_out, ir_out, a_out, alu_out, pc_inc, pc_load, mar_load, ir_load;
  logic a_load, b_load, out_load, flags_load, ram_rd, ram_wr, alu_sub, instr_done;
  logic halted, bus_err;
  logic [2:0] tstate;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [15:0] PCO = 16'h8000, IRO = 16'h4000, AO = 16'h2000, ALUO = 16'h1000,
    PCI = 16'h0800, PCL = 16'h0400, MARL = 16'h0200, IRL = 16'h0100,
    AL = 16'h0080, BL = 16'h0040, OUTL = 16'h0020, FL = 16'h0010,
    RD = 16'h0008, WR = 16'h0004, SUB = 16'h0002, DONE = 16'h0001;

  logic [15:0] strobes;
  assign strobes = {pc_out, ir_out, a_out, alu_out, pc_inc, pc_load, mar_load, ir_load,
                    a_load, b_load, out_load, flags_load, ram_rd, ram_wr, alu_sub, instr_done};

  cpu_control_sequencer dut (
    .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
    .mem_rdy(mem_rdy), .pc_out(pc_out), .ir_out(ir_out), .a_out(a_out), .alu_out(alu_out),
    .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load), .ir_load(ir_load),
    .a_load(a_load), .b_load(b_load), .out_load(out_load), .flags_load(flags_load),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .alu_sub(alu_sub), .instr_done(instr_done),
    .halted(halted), .bus_err(bus_err), .tstate(tstate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply mem_rdy, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input string tag, input logic rdy, input logic [2:0] exp_t,
                     input logic [15:0] exp_s, input logic exp_err = 1'b0);
    mem_rdy = rdy;
    @(negedge clk);
    chk({tag, ".tstate"}, 32'(tstate), 32'(exp_t));
    chk({tag, ".strobes"}, 32'(strobes), 32'(exp_s));
    chk({tag, ".halted"}, 32'(halted), 32'(exp_t == 3'd7));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic fetch(input string tag, input logic [3:0] op);
    opcode = op;
    cyc({tag, ".F0"}, 1'b1, 3'd0, PCO | MARL);
    cyc({tag, ".F1"}, 1'b1, 3'd1, RD | IRL | PCI);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst.tstate", 32'(tstate), 32'd0);
      chk("rst.strobes", 32'(strobes), 32'd0);
      chk("rst.halted", 32'(halted), 32'd0);
      chk("rst.bus_err", 32'(bus_err), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; mem_rdy = 1'b1; opcode = 4'h5; flag_c = 1'b0; flag_z = 1'b0;
    @(posedge clk); #1;
    do_reset();

    fetch("ldi", 4'h5);
    cyc("ldi.E0", 1'b1, 3'd2, IRO | AL | DONE);

    fetch("add", 4'h2);
    cyc("add.E0", 1'b1, 3'd2, IRO | MARL);
    cyc("add.E1", 1'b1, 3'd3, RD | BL);
    cyc("add.E2", 1'b1, 3'd4, ALUO | AL | FL | DONE);

    fetch("sub", 4'h3);
    cyc("sub.E0", 1'b1, 3'd2, IRO | MARL);
    cyc("sub.E1", 1'b1, 3'd3, RD | BL);
    cyc("sub.E2", 1'b1, 3'd4, ALUO | AL | FL | SUB | DONE);

    fetch("lda", 4'h1);
    cyc("lda.E0", 1'b1, 3'd2, IRO | MARL);
    for (int i = 0; i < 3; i++) cyc("lda.E1wait", 1'b0, 3'd3, RD);
    cyc("lda.E1", 1'b1, 3'd3, RD | AL | DONE);

    fetch("sta", 4'h4);
    cyc("sta.E0", 1'b1, 3'd2, IRO | MARL);
    cyc("sta.E1", 1'b1, 3'd3, AO | WR | DONE);

    fetch("jmp", 4'h6);
    cyc("jmp.E0", 1'b1, 3'd2, IRO | PCL | DONE);

    flag_c = 1'b0; flag_z = 1'b1;
    fetch("jc0", 4'h7);
    cyc("jc0.E0", 1'b1, 3'd2, DONE);
    flag_c = 1'b1; flag_z = 1'b0;
    fetch("jc1", 4'h7);
    cyc("jc1.E0", 1'b1, 3'd2, IRO | PCL | DONE);
    fetch("jz0", 4'h8);
    cyc("jz0.E0", 1'b1, 3'd2, DONE);
    flag_c = 1'b0; flag_z = 1'b1;
    fetch("jz1", 4'h8);
    cyc("jz1.E0", 1'b1, 3'd2, IRO | PCL | DONE);

    fetch("out", 4'hE);
    cyc("out.E0", 1'b1, 3'd2, AO | OUTL | DONE);
    fetch("nop", 4'h0);
    cyc("nop.E0", 1'b1, 3'd2, DONE);
    fetch("undef", 4'hA);
    cyc("undef.E0", 1'b1, 3'd2, DONE);

    // Freeze in the middle of LDA, then resume where it left off.
    fetch("frz", 4'h1);
    cyc("frz.E0", 1'b1, 3'd2, IRO | MARL);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) cyc("frz.hold", 1'b1, 3'd3, 16'h0000);
    ena = 1'b1;
    cyc("frz.E1", 1'b1, 3'd3, RD | AL | DONE);
    cyc("frz.F0", 1'b1, 3'd0, PCO | MARL);
    do_reset();

    // mem_rdy never arrives during fetch: 15 stalled F1 cycles, then HALT with bus_err.
    opcode = 4'h5;
    cyc("to.F0", 1'b1, 3'd0, PCO | MARL);
    for (int i = 0; i < 15; i++) cyc("to.F1", 1'b0, 3'd1, RD);
    cyc("to.halt", 1'b0, 3'd7, 16'h0000, 1'b1);
    cyc("to.halt2", 1'b1, 3'd7, 16'h0000, 1'b1);
    do_reset();
    cyc("to.clr", 1'b1, 3'd0, PCO | MARL);
    cyc("to.clrF1", 1'b1, 3'd1, RD | IRL | PCI);
    cyc("to.clrE0", 1'b1, 3'd2, IRO | AL | DONE);

    fetch("hlt", 4'hF);
    cyc("hlt.E0", 1'b1, 3'd2, DONE);
    for (int i = 0; i < 20; i++) cyc("hlt.hold", 1'b1, 3'd7, 16'h0000);
    do_reset();
    cyc("post.F0", 1'b1, 3'd0, PCO | MARL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
